// File: rtl/demux_1to4_router.sv
// rtl/demux_1to4_router.sv - registered 1-to-4 valid/ready router with one-entry holding stage
// Optional per-channel transfer counters are enabled by defining DEMUX_COUNT_EN.

module demux_1to4_router #(
  parameter int NBits   = 32,
  parameter int CntBits = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Selector,
  input  logic [NBits-1:0]     In_Data,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  output logic [NBits-1:0]     Out_Data,
  output logic [3:0]           Out_Valid,
  input  logic [3:0]           Out_Ready,
  input  logic                 Count_Clear,
  output logic [4*CntBits-1:0] Xfer_Count
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t           state_q;
  logic [1:0]       sel_q;
  logic [NBits-1:0] data_q;
  logic [3:0]       valid_q;

  logic deliver;
  logic accept;

  // Only the held word's sink is consulted; In_Valid never feeds In_Ready.
  assign deliver  = (state_q == ST_FULL) && Out_Ready[sel_q];
  assign In_Ready = (state_q == ST_EMPTY) || Out_Ready[sel_q];
  assign accept   = In_Valid && In_Ready;

  assign Out_Data  = data_q;
  assign Out_Valid = valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      sel_q   <= 2'b00;
      data_q  <= '0;
      valid_q <= 4'b0000;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            data_q  <= In_Data;
            sel_q   <= Selector;
            valid_q <= 4'b0001 << Selector;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (deliver) begin
            if (accept) begin
              data_q  <= In_Data;
              sel_q   <= Selector;
              valid_q <= 4'b0001 << Selector;
            end else begin
              valid_q <= 4'b0000;
              state_q <= ST_EMPTY;
            end
          end
        end
        default: begin
          valid_q <= 4'b0000;
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

`ifdef DEMUX_COUNT_EN
  logic [CntBits-1:0] cnt_q [4];
  logic [CntBits-1:0] cnt_d [4];

  // Clear wins over a same-edge delivery; counters wrap naturally.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
      if (Count_Clear)
        cnt_d[k] = '0;
      else if (deliver && (sel_q == 2'(k)))
        cnt_d[k] = cnt_q[k] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    Xfer_Count = '0;
    for (int k = 0; k < 4; k++) Xfer_Count[k*CntBits +: CntBits] = cnt_q[k];
  end
`else
  logic unused_count_clear;
  assign unused_count_clear = Count_Clear;
  assign Xfer_Count = '0;
`endif

endmodule

// File: tb/tb_demux_1to4_router.sv
// tb/tb_demux_1to4_router.sv - vector table, corner sequences and randomized model check for demux_1to4_router

module tb_demux_1to4_router;

  localparam int NB = 32;
  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    sel;
  logic [NB-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic          count_clear;
  logic [4*CB-1:0] xfer_count;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  demux_1to4_router #(.NBits(NB), .CntBits(CB)) dut (
    .clk(clk), .reset(reset), .Selector(sel), .In_Data(in_data),
    .In_Valid(in_valid), .In_Ready(in_ready), .Out_Data(out_data),
    .Out_Valid(out_valid), .Out_Ready(out_ready), .Count_Clear(count_clear),
    .Xfer_Count(xfer_count)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
    logic        iv;
    logic [3:0]  ordy;
    logic [3:0]  ev;
    logic [31:0] ed;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] s, logic [31:0] d, logic iv, logic [3:0] o,
                              logic [3:0] ev, logic [31:0] ed, logic er);
    vec_t v;
    v.sel = s; v.data = d; v.iv = iv; v.ordy = o; v.ev = ev; v.ed = ed; v.er = er;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic [1:0] s, logic [31:0] d, logic iv, logic [3:0] o, logic clr);
    sel = s; in_data = d; in_valid = iv; out_ready = o; count_clear = clr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(2'd0, 32'd0, 1'b0, 4'b0000, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [CB-1:0] exp_cnt(int n);
`ifdef DEMUX_COUNT_EN
    return CB'(n % 16);
`else
    return CB'(0 * n);
`endif
  endfunction

  // Reference model: the holding stage is a queue of at most one word.
  logic [31:0] mq_d[$];
  logic [1:0]  mq_s[$];
  int          mcnt[4];

  initial begin
    reset = 1'b1;
    drive(2'd0, 32'd0, 1'b0, 4'b0000, 1'b0);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_out_data", 64'(out_data), 64'h0);
    chk("reset_in_ready", 64'(in_ready), 64'h1);
    chk("reset_xfer_count", 64'(xfer_count), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table: single delivery, 5-cycle stall with foreign readies, stream, selector changes while held.
    vecs.push_back(mk(2'd2, 32'hDEADBEEF, 1, 4'b0100, 4'b0000, 32'h0, 1));
    vecs.push_back(mk(2'd0, 32'h0,        0, 4'b0100, 4'b0100, 32'hDEADBEEF, 1));
    vecs.push_back(mk(2'd1, 32'h11111111, 1, 4'b0000, 4'b0000, 32'hDEADBEEF, 1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(2'd0, 32'h22222222, 1, 4'b1101, 4'b0010, 32'h11111111, 0));
    vecs.push_back(mk(2'd0, 32'h0,        0, 4'b0010, 4'b0010, 32'h11111111, 1));
    vecs.push_back(mk(2'd0, 32'hA0,       1, 4'b1111, 4'b0000, 32'h11111111, 1));
    vecs.push_back(mk(2'd1, 32'hA1,       1, 4'b1111, 4'b0001, 32'hA0, 1));
    vecs.push_back(mk(2'd2, 32'hA2,       1, 4'b1111, 4'b0010, 32'hA1, 1));
    vecs.push_back(mk(2'd3, 32'hA3,       1, 4'b1111, 4'b0100, 32'hA2, 1));
    vecs.push_back(mk(2'd0, 32'hA4,       1, 4'b1111, 4'b1000, 32'hA3, 1));
    vecs.push_back(mk(2'd0, 32'h0,        0, 4'b1111, 4'b0001, 32'hA4, 1));
    vecs.push_back(mk(2'd0, 32'h0,        0, 4'b0000, 4'b0000, 32'hA4, 1));
    vecs.push_back(mk(2'd3, 32'hB3,       1, 4'b0111, 4'b0000, 32'hA4, 1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(2'(i), 32'hC0,    1, 4'b0111, 4'b1000, 32'hB3, 0));
    vecs.push_back(mk(2'd1, 32'h0,        0, 4'b1000, 4'b1000, 32'hB3, 1));
    vecs.push_back(mk(2'd1, 32'h0,        0, 4'b0000, 4'b0000, 32'hB3, 1));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].data, vecs[i].iv, vecs[i].ordy, 1'b0);
      #1;
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].ed));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].er));
    end

    // Async reset with a word held drops it immediately.
    @(negedge clk);
    drive(2'd1, 32'h5A5A5A5A, 1, 4'b0000, 1'b0);
    @(negedge clk);
    drive(2'd1, 32'h0, 0, 4'b0000, 1'b0);
    #1;
    chk("held_before_reset", 64'(out_valid), 64'b0010);
    #2 reset = 1'b1;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'h0);
    chk("midreset_out_data", 64'(out_data), 64'h0);
    chk("midreset_in_ready", 64'(in_ready), 64'h1);
    @(negedge clk);
    reset = 1'b0;
    drive(2'd1, 32'h0, 0, 4'b1111, 1'b0);
    #1;
    chk("postreset_no_delivery", 64'(out_valid), 64'h0);

    // 17 deliveries on ch0 wrap a 4-bit counter to 1; clear beats same-edge delivery.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(2'd0, 32'(i), 1, 4'b1111, 1'b0);
      @(negedge clk);
    end
    drive(2'd0, 32'h0, 0, 4'b1111, 1'b0);
    @(negedge clk);
    #1;
    chk("cnt_wrap_ch0", 64'(xfer_count[CB-1:0]), 64'(exp_cnt(17)));
    chk("cnt_other_ch", 64'(xfer_count[4*CB-1:CB]), 64'h0);
    drive(2'd0, 32'h77, 1, 4'b0000, 1'b0);
    @(negedge clk);
    drive(2'd0, 32'h0, 0, 4'b0001, 1'b1);
    #1;
    chk("clr_pending_deliver", 64'(out_valid), 64'b0001);
    @(negedge clk);
    drive(2'd0, 32'h0, 0, 4'b0000, 1'b0);
    #1;
    chk("clr_priority", 64'(xfer_count[CB-1:0]), 64'h0);
    chk("clr_delivered", 64'(out_valid), 64'h0);

    // Randomized run against the queue model.
    do_reset();
    for (int k = 0; k < 4; k++) mcnt[k] = 0;
    mq_d.delete();
    mq_s.delete();
    for (int c = 0; c < 600; c++) begin
      logic [3:0] ev;
      logic       er;
      logic       dlv;
      logic       clr;
      clr = ($urandom_range(0, 29) == 0);
      drive(2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)), clr);
      #1;
      ev  = (mq_s.size() != 0) ? (4'b0001 << mq_s[0]) : 4'b0000;
      er  = (mq_s.size() == 0) || out_ready[mq_s[0]];
      dlv = (mq_s.size() != 0) && out_ready[mq_s[0]];
      chk("rnd_out_valid", 64'(out_valid), 64'(ev));
      chk("rnd_in_ready", 64'(in_ready), 64'(er));
      if (mq_s.size() != 0) chk("rnd_out_data", 64'(out_data), 64'(mq_d[0]));
      for (int k = 0; k < 4; k++)
        chk($sformatf("rnd_cnt%0d", k), 64'(xfer_count[k*CB +: CB]), 64'(exp_cnt(mcnt[k])));
      if (dlv) begin
        if (!clr) mcnt[mq_s[0]]++;
        void'(mq_d.pop_front());
        void'(mq_s.pop_front());
      end
      if (clr) for (int k = 0; k < 4; k++) mcnt[k] = 0;
      if (in_valid && er) begin
        mq_d.push_back(in_data);
        mq_s.push_back(sel);
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
